alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- ID/EX pipeline stage that produces the ALU's control code and operands. It is the issuing end of the ALU_Cntrl/In1/In2 interface.
- Decodes ALUOp/funct3/funct7[5] into the 4-bit ALU_Cntrl encoding and selects the operand sources, including EX/MEM and MEM/WB forwarding.
- Registers the result into the EX stage, with valid, stall and flush control.
- Sits between the decoder/register file and the ALU in the pipelined core.

Parameters:
- XLEN, 32, datapath width of operands, immediate and forwarded results.
- REGW, 5, register-address width.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- id_valid  input  1  ID holds a real instruction
- stall  input  1  hold EX register contents (hazard unit)
- flush  input  1  replace EX contents with bubble (branch/exception)
- ALUOp  input  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU
- funct3  input  3  instruction funct3
- funct7_5  input  1  instruction bit 30
- ALUSrc  input  1  1: In2 takes imm, 0: In2 takes rs2 value
- RegWrite_id  input  1  instruction writes rd
- rs1, rs2, rd_id  input  REGW each  register addresses
- rs1_data, rs2_data  input  XLEN each  register-file read data
- imm  input  XLEN  sign-extended immediate
- exmem_RegWrite, memwb_RegWrite  input  1 each  older-stage write enables
- exmem_rd, memwb_rd  input  REGW each  older-stage destinations
- exmem_result, memwb_result  input  XLEN each  older-stage results
- ex_valid  output  1  EX stage holds a real instruction
- ALU_Cntrl  output  4  ALU operation code
- In1, In2  output  XLEN each  ALU operands
- rs2_fwd  output  XLEN  forwarded rs2 value (store data)
- rd_ex  output  REGW  destination
- RegWrite_ex  output  1  write enable to later stages
- illegal_ex  output  1  unsupported funct combination

Behaviour:
- Reset (rst_n low, asynchronous) sets:
  - ex_valid=0, RegWrite_ex=0, illegal_ex=0.
  - ALU_Cntrl=4'b0010.
  - In1=In2=rs2_fwd=0, rd_ex=0.
- Release of rst_n is sampled synchronously; first capture happens on the first rising edge with rst_n high.
- ALU_Cntrl encodings: AND 4'b0000, OR 4'b0001, ADD 4'b0010, SUB 4'b0110.
- Decode, combinational, registered with 1-cycle latency:
  - ALUOp 00 → ADD.
  - ALUOp 01 → SUB.
  - ALUOp 10 with funct3 000 → ADD if funct7_5=0, SUB if 1.
  - ALUOp 10 with funct3 111 → AND; funct3 110 → OR.
  - ALUOp 11 with funct3 000 → ADD, funct7_5 ignored.
  - ALUOp 11 with funct3 111 → AND; funct3 110 → OR.
  - Any other funct3 under ALUOp 10/11 → illegal: ALU_Cntrl=ADD, illegal_ex=1, RegWrite_ex forced 0.
- Forwarding, per source (rs1, rs2):
  - Take exmem_result if exmem_RegWrite && exmem_rd==rsX && rsX!=0.
  - Otherwise take memwb_result if memwb_RegWrite && memwb_rd==rsX && rsX!=0.
  - Otherwise take the register-file data.
  - EX/MEM beats MEM/WB.
  - Register x0 is never forwarded; its register-file data passes through.
- Operand assignment: In1 = forwarded rs1; In2 = imm if ALUSrc else forwarded rs2; rs2_fwd = forwarded rs2 regardless of ALUSrc.
- Update rule each rising edge, in priority order:
  1. flush=1 → bubble: ex_valid=0, RegWrite_ex=0, illegal_ex=0, other fields at reset values. Flush wins over stall.
  2. else stall=1 → all registers hold. Forwarding inputs are not re-sampled.
  3. else id_valid=0 → bubble, as for flush.
  4. else capture: ex_valid=1, plus decoded and forwarded values.
- Bubbles never assert RegWrite_ex or illegal_ex.
- Reset asserted mid-stall or mid-flush clears immediately, asynchronously.

Optional Feature:
- Macro ALU_SLT_EN.
- Defined: adds SLT code 4'b0111, decoded from funct3 010 under ALUOp 10 (funct7_5=0) and ALUOp 11; those cases are no longer illegal.
- Undefined: funct3 010 is illegal as above, and code 0111 is never issued.

Test Plan:
- Reset: hold rst_n=0 with random inputs → ex_valid=0, ALU_Cntrl=0010, In1=In2=0, RegWrite_ex=0. Deassert, then on the first edge with id_valid=1, ALUOp=10, funct3=000, funct7_5=1 → ALU_Cntrl=0110, ex_valid=1.
- Decode sweep:
  - ALUOp 00 / 01 → 0010 / 0110.
  - R-type 111 / 110 → 0000 / 0001.
  - I-type 000 with funct7_5=1 → 0010.
  - R-type funct3=100 → illegal_ex=1, RegWrite_ex=0, ALU_Cntrl=0010.
- Forwarding:
  - rs1=5, exmem_rd=5 (result 0xAAAA0000) and memwb_rd=5 (result 0x5555) both writing → In1=0xAAAA0000.
  - exmem_RegWrite=0 → In1=0x5555.
  - rs1=0 with a matching rd=0 → In1=rs1_data.
- ALUSrc: ALUSrc=1, imm=0xFFFFFFFC, rs2 forwarded 0x10 → In2=0xFFFFFFFC, rs2_fwd=0x10.
- Stall/flush: capture an ADD, then stall=1 for 3 cycles with changed inputs → outputs unchanged. Then stall=1 with flush=1 → ex_valid=0, RegWrite_ex=0 on that edge.
- ALU_SLT_EN:
  - Built with the macro: ALUOp=10, funct3=010 → ALU_Cntrl=0111, illegal_ex=0.
  - Built without it: same stimulus → illegal_ex=1, ALU_Cntrl=0010.

Source files
------------

// File: rtl/alu_issue_if.sv
// ALU issue bus: the registered EX-stage bundle that carries the ALU control
// code, operands, store data and write-back tags from the issue stage to the ALU.
// The bus has no back-pressure. A beat is a real instruction when ex_valid=1.
// When ex_valid=0 the beat is a bubble, and RegWrite_ex and illegal_ex are 0.
// The master drives every field. The slave only observes.
interface alu_issue_if #(
  parameter int XLEN = 32,
  parameter int REGW = 5
);
  logic            ex_valid;
  logic [3:0]      ALU_Cntrl;
  logic [XLEN-1:0] In1;
  logic [XLEN-1:0] In2;
  logic [XLEN-1:0] rs2_fwd;
  logic [REGW-1:0] rd_ex;
  logic            RegWrite_ex;
  logic            illegal_ex;

  modport master (
    output ex_valid, ALU_Cntrl, In1, In2, rs2_fwd, rd_ex, RegWrite_ex, illegal_ex
  );

  modport slave (
    input ex_valid, ALU_Cntrl, In1, In2, rs2_fwd, rd_ex, RegWrite_ex, illegal_ex
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes ALUOp/funct3/funct7[5] into ALU_Cntrl and resolves
// operands with EX/MEM > MEM/WB > register-file forwarding. It registers the
// result into EX. Flush beats stall, and stall beats capture.
// Optional build macro ALU_SLT_EN adds the SLT code (4'b0111) for funct3=010.
module alu_issue_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [1:0]       ALUOp,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             ALUSrc,
  input  logic             RegWrite_id,
  input  logic [REGW-1:0]  rs1,
  input  logic [REGW-1:0]  rs2,
  input  logic [REGW-1:0]  rd_id,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  imm,
  input  logic             exmem_RegWrite,
  input  logic             memwb_RegWrite,
  input  logic [REGW-1:0]  exmem_rd,
  input  logic [REGW-1:0]  memwb_rd,
  input  logic [XLEN-1:0]  exmem_result,
  input  logic [XLEN-1:0]  memwb_result,
  alu_issue_if.master      ex
);

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
`ifdef ALU_SLT_EN
  localparam logic [3:0] CTRL_SLT = 4'b0111;
`endif

  logic [3:0]      dec_ctrl;
  logic            dec_illegal;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic [XLEN-1:0] op2;

  logic            ex_valid_q;
  logic [3:0]      ctrl_q;
  logic [XLEN-1:0] in1_q;
  logic [XLEN-1:0] in2_q;
  logic [XLEN-1:0] rs2_fwd_q;
  logic [REGW-1:0] rd_q;
  logic            regwrite_q;
  logic            illegal_q;

  // Decode ALUOp/funct into the ALU control code. Illegal encodings fall back to ADD.
  always_comb begin
    dec_ctrl    = CTRL_ADD;
    dec_illegal = 1'b0;
    case (ALUOp)
      2'b00: dec_ctrl = CTRL_ADD;
      2'b01: dec_ctrl = CTRL_SUB;
      default: begin
        // ALUOp 10 (R-type) and 11 (I-type). Only R-type uses funct7[5] to select SUB.
        case (funct3)
          3'b000: dec_ctrl = (ALUOp == 2'b10 && funct7_5) ? CTRL_SUB : CTRL_ADD;
          3'b111: dec_ctrl = CTRL_AND;
          3'b110: dec_ctrl = CTRL_OR;
`ifdef ALU_SLT_EN
          3'b010: begin
            if (ALUOp == 2'b11 || !funct7_5) begin
              dec_ctrl = CTRL_SLT;
            end else begin
              dec_illegal = 1'b1;
            end
          end
`endif
          default: dec_illegal = 1'b1;
        endcase
      end
    endcase
  end

  // Operand forwarding. The youngest producer (EX/MEM) wins. x0 always reads the register file.
  always_comb begin
    fwd_rs1 = rs1_data;
    if (exmem_RegWrite && (exmem_rd == rs1) && (rs1 != '0)) begin
      fwd_rs1 = exmem_result;
    end else if (memwb_RegWrite && (memwb_rd == rs1) && (rs1 != '0)) begin
      fwd_rs1 = memwb_result;
    end

    fwd_rs2 = rs2_data;
    if (exmem_RegWrite && (exmem_rd == rs2) && (rs2 != '0)) begin
      fwd_rs2 = exmem_result;
    end else if (memwb_RegWrite && (memwb_rd == rs2) && (rs2 != '0)) begin
      fwd_rs2 = memwb_result;
    end

    op2 = ALUSrc ? imm : fwd_rs2;
  end

  // EX register: a flush or an empty ID slot inserts a bubble, and a stall holds every field.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ctrl_q     <= CTRL_ADD;
      in1_q      <= '0;
      in2_q      <= '0;
      rs2_fwd_q  <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (flush || (!stall && !id_valid)) begin
      ex_valid_q <= 1'b0;
      ctrl_q     <= CTRL_ADD;
      in1_q      <= '0;
      in2_q      <= '0;
      rs2_fwd_q  <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (!stall) begin
      ex_valid_q <= 1'b1;
      ctrl_q     <= dec_ctrl;
      in1_q      <= fwd_rs1;
      in2_q      <= op2;
      rs2_fwd_q  <= fwd_rs2;
      rd_q       <= rd_id;
      regwrite_q <= RegWrite_id && !dec_illegal;
      illegal_q  <= dec_illegal;
    end
  end

  assign ex.ex_valid    = ex_valid_q;
  assign ex.ALU_Cntrl   = ctrl_q;
  assign ex.In1         = in1_q;
  assign ex.In2         = in2_q;
  assign ex.rs2_fwd     = rs2_fwd_q;
  assign ex.rd_ex       = rd_q;
  assign ex.RegWrite_ex = regwrite_q;
  assign ex.illegal_ex  = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed vectors, expected EX bundles queued by the
// driver, popped and compared by a monitor on the falling edge.
module tb_alu_issue_stage;

  localparam int XLEN = 32;
  localparam int REGW = 5;
  localparam int W    = 1 + 4 + 3 * XLEN + REGW + 1 + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             id_valid, stall, flush, funct7_5, ALUSrc, RegWrite_id;
  logic [1:0]       ALUOp;
  logic [2:0]       funct3;
  logic [REGW-1:0]  rs1, rs2, rd_id, exmem_rd, memwb_rd;
  logic [XLEN-1:0]  rs1_data, rs2_data, imm, exmem_result, memwb_result;
  logic             exmem_RegWrite, memwb_RegWrite;

  alu_issue_if #(.XLEN(XLEN), .REGW(REGW)) ex_if ();

  alu_issue_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .stall(stall), .flush(flush),
    .ALUOp(ALUOp), .funct3(funct3), .funct7_5(funct7_5), .ALUSrc(ALUSrc),
    .RegWrite_id(RegWrite_id), .rs1(rs1), .rs2(rs2), .rd_id(rd_id),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .exmem_RegWrite(exmem_RegWrite), .memwb_RegWrite(memwb_RegWrite),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_result(exmem_result), .memwb_result(memwb_result),
    .ex(ex_if)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  function automatic logic [W-1:0] mk(input logic v, input logic [3:0] c,
                                      input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                      input logic [XLEN-1:0] f, input logic [REGW-1:0] rd,
                                      input logic rw, input logic ill);
    return {v, c, a, b, f, rd, rw, ill};
  endfunction

  function automatic logic [W-1:0] actual();
    return {ex_if.ex_valid, ex_if.ALU_Cntrl, ex_if.In1, ex_if.In2, ex_if.rs2_fwd,
            ex_if.rd_ex, ex_if.RegWrite_ex, ex_if.illegal_ex};
  endfunction

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got v=%b c=%b in1=%h in2=%h fwd=%h rd=%0d rw=%b ill=%b, expected v=%b c=%b in1=%h in2=%h fwd=%h rd=%0d rw=%b ill=%b",
               nm, act[W-1], act[W-2 -: 4], act[W-6 -: XLEN], act[W-6-XLEN -: XLEN],
               act[W-6-2*XLEN -: XLEN], act[REGW+1 : 2], act[1], act[0],
               exp[W-1], exp[W-2 -: 4], exp[W-6 -: XLEN], exp[W-6-XLEN -: XLEN],
               exp[W-6-2*XLEN -: XLEN], exp[REGW+1 : 2], exp[1], exp[0]);
    end
  endtask

  // Monitor: after each rising edge, compare the EX bundle with the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      check(name_q.pop_front(), actual(), exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_defaults();
    id_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    ALUOp = 2'b00; funct3 = 3'b000; funct7_5 = 1'b0; ALUSrc = 1'b0; RegWrite_id = 1'b1;
    rs1 = 5'd1; rs2 = 5'd2; rd_id = 5'd3;
    rs1_data = 32'd100; rs2_data = 32'd7; imm = 32'd8;
    exmem_RegWrite = 1'b0; memwb_RegWrite = 1'b0;
    exmem_rd = 5'd0; memwb_rd = 5'd0; exmem_result = 32'd0; memwb_result = 32'd0;
  endtask

  task automatic rtype(input logic [1:0] op, input logic [2:0] f3, input logic f7);
    id_valid = 1'b1; ALUOp = op; funct3 = f3; funct7_5 = f7;
  endtask

  // Queue an expectation for the coming rising edge, then move to just past the falling edge.
  task automatic issue(input string nm, input logic [W-1:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  localparam logic [W-1:0] BUBBLE = {1'b0, 4'b0010, {(3*XLEN+REGW+2){1'b0}}};

  initial begin
    rst_n = 1'b0;
    set_defaults();
    @(negedge clk);
    #1;

    // Reset with random inputs applied
    for (int i = 0; i < 2; i++) begin
      id_valid = 1'b1; ALUOp = 2'($urandom_range(0, 3)); funct3 = 3'($urandom_range(0, 7));
      rs1_data = $urandom; rs2_data = $urandom; imm = $urandom; exmem_result = $urandom;
      issue("reset", BUBBLE);
    end

    // First edge after release captures
    rst_n = 1'b1;
    set_defaults();
    rtype(2'b10, 3'b000, 1'b1);
    issue("first_sub", mk(1, 4'b0110, 100, 7, 7, 3, 1, 0));

    // Decode sweep
    set_defaults(); rtype(2'b00, 3'b101, 1'b1); ALUSrc = 1'b1;
    issue("ld_st_add", mk(1, 4'b0010, 100, 8, 7, 3, 1, 0));
    set_defaults(); rtype(2'b01, 3'b001, 1'b0); RegWrite_id = 1'b0;
    issue("branch_sub", mk(1, 4'b0110, 100, 7, 7, 3, 0, 0));
    set_defaults(); rtype(2'b10, 3'b111, 1'b0);
    issue("r_and", mk(1, 4'b0000, 100, 7, 7, 3, 1, 0));
    set_defaults(); rtype(2'b10, 3'b110, 1'b0);
    issue("r_or", mk(1, 4'b0001, 100, 7, 7, 3, 1, 0));
    set_defaults(); rtype(2'b11, 3'b000, 1'b1); ALUSrc = 1'b1;
    issue("i_add_f7", mk(1, 4'b0010, 100, 8, 7, 3, 1, 0));
    set_defaults(); rtype(2'b11, 3'b111, 1'b0); ALUSrc = 1'b1;
    issue("i_and", mk(1, 4'b0000, 100, 8, 7, 3, 1, 0));
    set_defaults(); rtype(2'b10, 3'b100, 1'b0);
    issue("r_illegal", mk(1, 4'b0010, 100, 7, 7, 3, 0, 1));

    // funct3=010 depends on the optional SLT build
    set_defaults(); rtype(2'b10, 3'b010, 1'b0);
`ifdef ALU_SLT_EN
    issue("r_slt", mk(1, 4'b0111, 100, 7, 7, 3, 1, 0));
`else
    issue("r_slt_illegal", mk(1, 4'b0010, 100, 7, 7, 3, 0, 1));
`endif
    set_defaults(); rtype(2'b11, 3'b010, 1'b1); ALUSrc = 1'b1;
`ifdef ALU_SLT_EN
    issue("i_slt", mk(1, 4'b0111, 100, 8, 7, 3, 1, 0));
`else
    issue("i_slt_illegal", mk(1, 4'b0010, 100, 8, 7, 3, 0, 1));
`endif

    // Forwarding priority
    set_defaults(); rtype(2'b00, 3'b000, 1'b0);
    rs1 = 5'd5; rs1_data = 32'h1234;
    exmem_RegWrite = 1'b1; exmem_rd = 5'd5; exmem_result = 32'hAAAA0000;
    memwb_RegWrite = 1'b1; memwb_rd = 5'd5; memwb_result = 32'h5555;
    issue("fwd_exmem_wins", mk(1, 4'b0010, 32'hAAAA0000, 7, 7, 3, 1, 0));
    exmem_RegWrite = 1'b0;
    issue("fwd_memwb", mk(1, 4'b0010, 32'h5555, 7, 7, 3, 1, 0));
    rs1 = 5'd0; rs1_data = 32'h77;
    exmem_RegWrite = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
    issue("fwd_x0", mk(1, 4'b0010, 32'h77, 7, 7, 3, 1, 0));

    // ALUSrc picks imm while store data keeps the forwarded rs2
    set_defaults(); rtype(2'b00, 3'b000, 1'b0);
    ALUSrc = 1'b1; imm = 32'hFFFFFFFC; rs2 = 5'd6;
    exmem_RegWrite = 1'b1; exmem_rd = 5'd6; exmem_result = 32'h10;
    issue("alusrc_imm", mk(1, 4'b0010, 100, 32'hFFFFFFFC, 32'h10, 3, 1, 0));
    set_defaults(); rtype(2'b10, 3'b000, 1'b0); rs2 = 5'd6;
    exmem_RegWrite = 1'b1; exmem_rd = 5'd9; exmem_result = 32'h10;
    memwb_RegWrite = 1'b1; memwb_rd = 5'd6; memwb_result = 32'h20;
    issue("fwd_rs2_memwb", mk(1, 4'b0010, 100, 32'h20, 32'h20, 3, 1, 0));

    // Stall holds, then flush overrides stall
    set_defaults(); rtype(2'b00, 3'b000, 1'b0); rd_id = 5'd4;
    issue("capture_add", mk(1, 4'b0010, 100, 7, 7, 4, 1, 0));
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ALUOp = 2'b01; rs1_data = 32'd999 + 32'(i); rd_id = 5'd9;
      exmem_RegWrite = 1'b1; exmem_rd = 5'd1; exmem_result = 32'hDEAD;
      issue("stall_hold", mk(1, 4'b0010, 100, 7, 7, 4, 1, 0));
    end
    flush = 1'b1;
    issue("flush_over_stall", BUBBLE);

    // Empty ID slot gives a bubble; a plain flush also gives one
    set_defaults(); rtype(2'b10, 3'b111, 1'b0);
    issue("recapture_and", mk(1, 4'b0000, 100, 7, 7, 3, 1, 0));
    id_valid = 1'b0;
    issue("idle_bubble", BUBBLE);
    rtype(2'b10, 3'b110, 1'b0);
    issue("recapture_or", mk(1, 4'b0001, 100, 7, 7, 3, 1, 0));
    flush = 1'b1;
    issue("flush_bubble", BUBBLE);

    // Asynchronous reset while stalled clears between edges
    set_defaults(); rtype(2'b01, 3'b000, 1'b0);
    issue("pre_async", mk(1, 4'b0110, 100, 7, 7, 3, 1, 0));
    stall = 1'b1;
    rst_n = 1'b0;
    #1;
    check("async_reset", actual(), BUBBLE);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    set_defaults();

    // Drain with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
